ram8_write_arbiter: RTL

- Round-robin arbiter sharing one RAM8-style write port among 8 requesters.
- Drives the 3-bit select, the load strobe, the address and the data for the downstream 8-way load demultiplexer and register bank.
- Supports bounded write bursts per grant.
- Sits between producer blocks (CPU store path, DMA, I/O) and the shared memory write port.

---
 rtl/ram8_write_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/ram8_write_arbiter.sv
// Round-robin arbiter granting one of 8 requesters a shared RAM8 write port, with bounded bursts per grant.
// Optional macro ARB_LOCK_EN adds a lock input that holds the grant past MAX_BURST until the requester drops.
module ram8_write_arbiter #(
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                reset,
`ifdef ARB_LOCK_EN
   input  logic                lock,
`endif
   input  logic [7:0]          req,
   input  logic [8*ADDR_W-1:0] addr_flat,
   input  logic [8*DATA_W-1:0] data_flat,
   output logic [7:0]          gnt,
   output logic [2:0]          sel,
   output logic                mem_load,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_data,
   output logic                busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

   state_t     state_q, state_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] sel_q, sel_d;
   logic [2:0] last_q, last_d;
   logic [3:0] beat_q, beat_d;
   logic       lock_eff;
   logic       release_c;
   logic       win_vld;
   logic [2:0] win_idx;
   logic [2:0] arb_last;

`ifdef ARB_LOCK_EN
   assign lock_eff = lock;
`else
   assign lock_eff = 1'b0;
`endif

   // Scan downward so the closest index after 'last' is the one left standing.
   function automatic logic [3:0] arbitrate(input logic [7:0] r, input logic [2:0] last);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      for (int i = 8; i >= 1; i--) begin
         idx = last + 3'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign busy     = (state_q == GRANT);
   assign gnt      = gnt_q;
   assign sel      = sel_q;
   assign mem_load = busy & req[sel_q];
   assign mem_addr = addr_flat[sel_q*ADDR_W +: ADDR_W];
   assign mem_data = data_flat[sel_q*DATA_W +: DATA_W];

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      last_d    = last_q;
      beat_d    = beat_q;
      release_c = busy & (~req[sel_q] | (mem_load & (beat_q == LAST_BEAT) & ~lock_eff));
      // At a release edge the just-served requester becomes lowest priority.
      arb_last  = busy ? sel_q : last_q;
      {win_vld, win_idx} = arbitrate(req, arb_last);
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = GRANT;
               gnt_d   = 8'b1 << win_idx;
               sel_d   = win_idx;
               beat_d  = 4'd0;
            end
         end
         GRANT: begin
            if (release_c) begin
               last_d = sel_q;
               beat_d = 4'd0;
               if (win_vld) begin
                  gnt_d = 8'b1 << win_idx;
                  sel_d = win_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 8'd0;
               end
            end else if (mem_load && beat_q != LAST_BEAT) begin
               beat_d = beat_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 8'd0;
         sel_q   <= 3'd0;
         last_q  <= 3'd7;
         beat_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
      end
   end

endmodule
